// File: rtl/decode_pipe_if.sv
// decode_pipe_if: fetch-side, execute-side and writeback signals of the decode stage
interface decode_pipe_if #(
   parameter int XLEN      = 32,
   parameter int RF_AWIDTH = 5
);
   logic                 in_valid;
   logic                 in_ready;
   logic [31:0]          in_instr;
   logic [XLEN-1:0]      in_pc;
   logic                 flush;
   logic                 wb_valid;
   logic [RF_AWIDTH-1:0] wb_rd;
   logic                 out_valid;
   logic                 out_ready;
   logic [3:0]           out_class;
   logic [RF_AWIDTH-1:0] out_rs1;
   logic [RF_AWIDTH-1:0] out_rs2;
   logic [RF_AWIDTH-1:0] out_rd;
   logic                 out_rd_we;
   logic [XLEN-1:0]      out_imm;
   logic [2:0]           out_funct3;
   logic [6:0]           out_funct7;
   logic [XLEN-1:0]      out_pc;
   modport master (
      output in_valid, in_instr, in_pc, flush, wb_valid, wb_rd, out_ready,
      input  in_ready, out_valid, out_class, out_rs1, out_rs2, out_rd, out_rd_we,
             out_imm, out_funct3, out_funct7, out_pc
   );
   modport slave (
      input  in_valid, in_instr, in_pc, flush, wb_valid, wb_rd, out_ready,
      output in_ready, out_valid, out_class, out_rs1, out_rs2, out_rd, out_rd_we,
             out_imm, out_funct3, out_funct7, out_pc
   );
endinterface

// File: rtl/decode_pipe.sv
// decode_pipe: registered RV32 decode stage with valid/ready, flush and a pending-write scoreboard
module decode_pipe #(
   parameter int XLEN       = 32,
   parameter int RF_AWIDTH  = 5,
   parameter bit ENABLE_AMO = 1
) (
   input logic          clk,
   input logic          rst,
   decode_pipe_if.slave bus
);
   localparam logic [3:0] C_ALUR = 4'd0, C_ALUI = 4'd1, C_LOAD = 4'd2, C_STORE = 4'd3,
                          C_BRANCH = 4'd4, C_LUI = 4'd5, C_AUIPC = 4'd6, C_JAL = 4'd7,
                          C_JALR = 4'd8, C_SYSTEM = 4'd9, C_AMO = 4'd10, C_ILLEGAL = 4'd15;
   // one bit per class code: which classes read rs1/rs2 and write rd unconditionally
   localparam logic [15:0] RS1_MASK = 16'h051F, RS2_MASK = 16'h0419, RD_MASK = 16'h05E7;
   localparam int NREG = 2 ** RF_AWIDTH;

   typedef struct packed {
      logic [3:0]           cls;
      logic [RF_AWIDTH-1:0] rs1;
      logic [RF_AWIDTH-1:0] rs2;
      logic [RF_AWIDTH-1:0] rd;
      logic                 we;
      logic [XLEN-1:0]      imm;
      logic [2:0]           f3;
      logic [6:0]           f7;
      logic [XLEN-1:0]      pc;
   } dec_t;

   dec_t            dec, out_q;
   logic            out_valid_q, out_valid_d;
   logic [NREG-1:0] busy_q, busy_d;
   logic            rs1_rd, rs2_rd, hazard, accept;
   logic [31:0]     ins;

   assign ins = bus.in_instr;

   always_comb begin
      dec.rs1 = RF_AWIDTH'(ins[19:15]);
      dec.rs2 = RF_AWIDTH'(ins[24:20]);
      dec.rd  = RF_AWIDTH'(ins[11:7]);
      dec.f3  = ins[14:12];
      dec.f7  = ins[31:25];
      dec.pc  = bus.in_pc;
      case (ins[6:0])
         7'b0110011: dec.cls = C_ALUR;
         7'b0010011: dec.cls = C_ALUI;
         7'b0000011: dec.cls = C_LOAD;
         7'b0100011: dec.cls = C_STORE;
         7'b1100011: dec.cls = C_BRANCH;
         7'b0110111: dec.cls = C_LUI;
         7'b0010111: dec.cls = C_AUIPC;
         7'b1101111: dec.cls = C_JAL;
         7'b1100111: dec.cls = C_JALR;
         7'b1110011: dec.cls = C_SYSTEM;
         7'b0101111: dec.cls = (ENABLE_AMO && ins[14:12] == 3'b010) ? C_AMO : C_ILLEGAL;
         default:    dec.cls = C_ILLEGAL;
      endcase
      case (dec.cls)
         C_ALUI, C_LOAD, C_JALR, C_SYSTEM: dec.imm = XLEN'($signed(ins[31:20]));
         C_STORE:      dec.imm = XLEN'($signed({ins[31:25], ins[11:7]}));
         C_BRANCH:     dec.imm = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
         C_LUI, C_AUIPC: dec.imm = XLEN'($signed({ins[31:12], 12'b0}));
         C_JAL:        dec.imm = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
         default:      dec.imm = '0;
      endcase
      rs1_rd = RS1_MASK[dec.cls] || (dec.cls == C_SYSTEM && !ins[14]);
      rs2_rd = RS2_MASK[dec.cls];
      dec.we = (RD_MASK[dec.cls] || (dec.cls == C_SYSTEM && ins[14:12] != 3'b0)) && dec.rd != '0;
      hazard = (rs1_rd && busy_q[dec.rs1]) || (rs2_rd && busy_q[dec.rs2]) || (dec.we && busy_q[dec.rd]);
   end

   assign bus.in_ready = !rst && !bus.flush && !hazard && (!out_valid_q || bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;

   always_comb begin
      busy_d = busy_q;
      if (bus.flush && out_valid_q && out_q.we) busy_d[out_q.rd] = 1'b0;
      if (bus.wb_valid && bus.wb_rd != '0) busy_d[bus.wb_rd] = 1'b0;
      if (accept && dec.we) busy_d[dec.rd] = 1'b1;
      out_valid_d = bus.flush ? 1'b0 : accept ? 1'b1 : bus.out_ready ? 1'b0 : out_valid_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         busy_q      <= '0;
         out_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         if (accept) out_q <= dec;
      end
   end

   assign bus.out_valid  = out_valid_q;
   assign bus.out_class  = out_q.cls;
   assign bus.out_rs1    = out_q.rs1;
   assign bus.out_rs2    = out_q.rs2;
   assign bus.out_rd     = out_q.rd;
   assign bus.out_rd_we  = out_q.we;
   assign bus.out_imm    = out_q.imm;
   assign bus.out_funct3 = out_q.f3;
   assign bus.out_funct7 = out_q.f7;
   assign bus.out_pc     = out_q.pc;
endmodule

// File: doc/decode_pipe.md
# decode_pipe

Parametrised, registered RISC-V instruction-decode stage with a valid/ready handshake, flush, and a per-register pending-write scoreboard. It replaces the purely combinational decode by holding one decoded instruction in an output register and stalling on read-after-write and write-after-write hazards until writeback. It sits between fetch and execute, and optionally decodes the A-extension.

## Interface
Parameters:
- XLEN, 32: datapath width; `pc`, `imm` and `out_pc` widths.
- RF_AWIDTH, 5: register address width; the scoreboard has 2**RF_AWIDTH bits.
- ENABLE_AMO, 1: when 1, opcode 0101111 with funct3=010 decodes as class AMO; when 0, the whole opcode is illegal.

Ports:
- clk  in  1  clock; everything changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  decode accepts the instruction this cycle.
- in_instr  in  32  raw instruction.
- in_pc  in  XLEN  PC of the instruction.
- flush  in  1  kill the held instruction and refuse input this cycle.
- wb_valid  in  1  writeback completes.
- wb_rd  in  RF_AWIDTH  destination register being written back.
- out_valid  out  1  a decoded instruction is held.
- out_ready  in  1  execute consumes the held instruction.
- out_class  out  4  0 ALU_R, 1 ALU_I, 2 LOAD, 3 STORE, 4 BRANCH, 5 LUI, 6 AUIPC, 7 JAL, 8 JALR, 9 SYSTEM, 10 AMO, 15 ILLEGAL.
- out_rs1, out_rs2, out_rd  out  RF_AWIDTH each  instruction fields.
- out_rd_we  out  1  the instruction writes a register and rd≠0.
- out_imm  out  XLEN  sign-extended immediate.
- out_funct3  out  3  funct3 field.
- out_funct7  out  7  funct7 field.
- out_pc  out  XLEN  registered copy of `in_pc`.

## Operation
- Registers read: rs1 is read by ALU_R, ALU_I, LOAD, STORE, BRANCH, JALR, AMO and SYSTEM with funct3[2]=0. rs2 is read by ALU_R, STORE, BRANCH and AMO.
- Register written: rd is written by ALU_R, ALU_I, LOAD, LUI, AUIPC, JAL, JALR, AMO and SYSTEM with funct3≠0. The write counts only when rd≠0.
- Immediate formats, sign-extended from bit 31 to XLEN: I for ALU_I, LOAD, JALR and SYSTEM; S for STORE; B for BRANCH; U for LUI and AUIPC; J for JAL. ALU_R, AMO and ILLEGAL output imm = 0.
- Illegal instructions: an unknown opcode, or `in_instr[1:0]`≠11. ILLEGAL sets out_rd_we = 0, reads no registers, and is still passed downstream.
- Hazard: the instruction stalls if it reads a register whose busy bit is set, or writes a register whose busy bit is set. x0 is never busy.
- Acceptance: in_ready = !rst && !flush && !hazard && (!out_valid || out_ready). An instruction is accepted when in_valid && in_ready; it loads the output register and sets busy[rd] when out_rd_we.
- Writeback: wb_valid with wb_rd≠0 clears busy[wb_rd]. wb_rd = 0 is ignored.
- Set and clear of the same register in one cycle: the set wins.
- Consumption: out_valid && out_ready with no new acceptance clears out_valid. Acceptance and consumption in the same cycle give a back-to-back transfer.
- Flush: sets out_valid to 0. If the held instruction had out_rd_we, its busy bit is cleared. Any wb_valid in the same cycle still clears its own bit.
- Reset: out_valid and all busy bits become 0; every out_* data output becomes 0.

## Timing
- Latency: an instruction accepted at edge N is visible on the outputs after edge N. Throughput is one instruction per cycle when there is no hazard and out_ready is held high.
- in_ready is combinational from in_instr, the busy bits, flush, out_valid and out_ready.
- Writeback at edge N clears the busy bit, so a stalled dependent instruction is accepted at edge N+1. There is no writeback-to-decode bypass.
- Output data stays stable while out_valid && !out_ready.
- Reset asserted mid-stall drops the held instruction. in_ready is 0 during reset.

## Test plan
- ADD x3,x1,x2 (0x002081B3), pc 0x0, with out_ready=1: one cycle later out_class=0, rs1=1, rs2=2, rd=3, out_rd_we=1. busy[3]=1.
- Next, ADD x4,x3,x1 (0x00118233): in_ready=0 until wb_valid with wb_rd=3 is seen, then the instruction is accepted on the following edge.
- LW x5,-4(x2) (0xFFC12283): out_class=2, out_imm=0xFFFFFFFC, rd=5.
- Hold out_ready=0 for 3 cycles with an instruction held: outputs are stable and in_ready=0. Then set out_ready=1 with a new valid input: back-to-back transfer with no bubble.
- Flush while holding rd=7: out_valid=0 next cycle and busy[7]=0. An instruction reading x7 is then accepted at once.
- Drive 0x1002A12F (LR.W) with ENABLE_AMO=1: out_class=10. With ENABLE_AMO=0: out_class=15 and out_rd_we=0. Drive 0xFFFFFFFF: out_class=15.
